// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default reset PC and instruction size.
package ifu_fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam int unsigned INST_BYTES       = 32'd4;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and hands pc/inst with a write-enable pulse to decode.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             redirect_valid_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   input  logic             stall_i,
   output logic             imem_req_valid_o,
   input  logic             imem_req_ready_i,
   output logic [XLEN-1:0]  imem_req_addr_o,
   input  logic             imem_resp_valid_i,
   input  logic [XLEN-1:0]  imem_resp_data_i,
   output logic             we_o,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  inst_o
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'd3));
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

   fetch_state_e    state_q,    state_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] req_pc_q,   req_pc_d;
   logic            kill_q,     kill_d;
   logic [XLEN-1:0] pc_buf_q,   pc_buf_d;
   logic [XLEN-1:0] inst_buf_q, inst_buf_d;

   logic [XLEN-1:0] target_s;
   logic            req_valid_s;
   logic            we_s;

   // State and datapath registers; reset abandons any in-flight transaction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         kill_q     <= 1'b0;
         pc_buf_q   <= '0;
         inst_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         pc_buf_q   <= pc_buf_d;
         inst_buf_q <= inst_buf_d;
      end
   end

   // Next-state logic; a redirect overrides every other event in each state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      kill_d      = kill_q;
      pc_buf_d    = pc_buf_q;
      inst_buf_d  = inst_buf_q;
      req_valid_s = 1'b0;
      we_s        = 1'b0;
      target_s    = redirect_pc_i & ALIGN_MASK;

      case (state_q)
         ST_REQ: begin
            req_valid_s = 1'b1;
            // An accepted handshake is a real transaction even when a redirect
            // lands in the same cycle, so its response must be thrown away.
            if (imem_req_ready_i) begin
               req_pc_d = pc_q;
               kill_d   = redirect_valid_i;
               state_d  = ST_WAIT;
            end else begin
               state_d  = ST_REQ;
            end
            if (redirect_valid_i) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
         end

         ST_WAIT: begin
            if (redirect_valid_i) begin
               pc_d = target_s;
               if (imem_resp_valid_i) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (imem_resp_valid_i) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  inst_buf_d = imem_resp_data_i;
                  pc_buf_d   = req_pc_q;
                  state_d    = ST_HOLD;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end

         ST_HOLD: begin
            if (redirect_valid_i) begin
               pc_d    = target_s;
               state_d = ST_REQ;
            end else if (!stall_i) begin
               we_s    = 1'b1;
               pc_d    = pc_buf_q + PC_STEP;
               state_d = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end

         default: begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
         end
      endcase
   end

   assign imem_req_valid_o = req_valid_s & ~reset;
   assign imem_req_addr_o  = pc_q;
   assign we_o             = we_s & ~reset;
   assign pc_o             = pc_buf_q;
   assign inst_o           = inst_buf_q;

endmodule
